// File: rtl/uart_receiver.sv
// 16x-oversampled 8N1 UART receive engine with start-glitch rejection and framing-error detection.
// Optional even-parity (8E1) reception is enabled by defining UART_RX_PARITY_EN.
module uart_receiver #(
    parameter int DATA_BITS    = 8,
    parameter int START_SAMPLE = 7
) (
    input  logic                 br_clk_16,
    input  logic                 reset,
    input  logic                 UART_RX,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_STATUS,
    output logic                 RX_FERR,
    output logic                 RX_PERR,
    output logic                 RX_BUSY
);

    localparam int DW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t               state, state_nxt;
    logic [3:0]           cnt, cnt_nxt;
    logic [DW-1:0]        dcnt, dcnt_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 status_nxt, ferr_nxt;
    logic                 rx_meta, rx_s;

    // Two-flop synchronizer, preset to idle-high so reset never looks like a start bit
    always_ff @(posedge br_clk_16) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_err, par_err_nxt, perr_nxt;
`endif

    always_ff @(posedge br_clk_16) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            dcnt      <= '0;
            shreg     <= '0;
            RX_DATA   <= '0;
            RX_STATUS <= 1'b0;
            RX_FERR   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            dcnt      <= dcnt_nxt;
            shreg     <= shreg_nxt;
            RX_DATA   <= data_nxt;
            RX_STATUS <= status_nxt;
            RX_FERR   <= ferr_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge br_clk_16) begin
        if (reset) begin
            par_err <= 1'b0;
            RX_PERR <= 1'b0;
        end else begin
            par_err <= par_err_nxt;
            RX_PERR <= perr_nxt;
        end
    end
`else
    assign RX_PERR = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + 4'd1;
        dcnt_nxt   = dcnt;
        shreg_nxt  = shreg;
        data_nxt   = RX_DATA;
        status_nxt = 1'b0;
        ferr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_nxt = par_err;
        perr_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                // Line must still be low mid-start-bit, otherwise it was a glitch
                if (cnt == 4'(START_SAMPLE)) begin
                    cnt_nxt  = '0;
                    dcnt_nxt = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == 4'd15) begin
                    shreg_nxt = shreg >> 1;
                    shreg_nxt[DATA_BITS-1] = rx_s;
                    dcnt_nxt = dcnt + DW'(1);
                    if (dcnt == DW'(DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == 4'd15) begin
                    par_err_nxt = (^shreg) ^ rx_s;
                    state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop-bit so a following start edge is not missed
                if (cnt == 4'd15) begin
                    if (rx_s) begin
                        state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_err) begin
                            perr_nxt = 1'b1;
                        end else begin
                            data_nxt   = shreg;
                            status_nxt = 1'b1;
                        end
`else
                        data_nxt   = shreg;
                        status_nxt = 1'b1;
`endif
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_nxt = '0;
                if (rx_s) state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign RX_BUSY = (state != IDLE);

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART receive engine; the counterpart to the team's 16x-oversampled UART transmitter.
- Format: 8N1, LSB first, idle-high line. All timing runs on br_clk_16, which ticks at 16x the baud rate.
- Recovers bytes from UART_RX and presents each on RX_DATA with a one-cycle RX_STATUS strobe for the CPU peripheral/MMIO layer.
- Flags framing errors and tolerates start-bit glitches.

Parameters:
- DATA_BITS, 8, number of data bits per frame (LSB first).
- START_SAMPLE, 7, br_clk_16 count at which the start bit is confirmed (mid-bit for 16x oversampling).

Ports:
- br_clk_16  input  1  16x baud clock; sole clock.
- reset  input  1  synchronous, active-high reset.
- UART_RX  input  1  serial line, asynchronous to br_clk_16; idle = 1.
- RX_DATA  output  DATA_BITS  last correctly framed byte; holds until the next good frame.
- RX_STATUS  output  1  one-cycle pulse: RX_DATA has just been updated.
- RX_FERR  output  1  one-cycle pulse: stop bit sampled as 0.
- RX_PERR  output  1  one-cycle parity-error pulse; tied 0 unless UART_RX_PARITY_EN.
- RX_BUSY  output  1  1 while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (synchronous, checked every posedge br_clk_16):
  - RX_DATA=0, RX_STATUS=0, RX_FERR=0, RX_PERR=0, RX_BUSY=0.
  - state=IDLE; bit counter cnt (4b)=0; data counter=0; shift register=0.
  - Synchronizer flops preset to 1.
  - Reset mid-frame abandons the frame silently: no strobe, RX_DATA returns to 0.
- Input sync: UART_RX passes through 2 flops (rx_s); all decisions use rx_s. Pad-to-rx_s latency is 2 cycles.
- IDLE:
  - cnt=0.
  - rx_s==0 -> START, cnt=0.
- START:
  - cnt increments each cycle.
  - At cnt==START_SAMPLE: if rx_s==1 (glitch) -> IDLE with no flags; else -> DATA, cnt=0, data counter=0.
- DATA:
  - cnt runs 0..15.
  - At cnt==15 (centre of a bit): shift rx_s in as bit[data counter], LSB first; increment data counter; cnt wraps to 0.
  - After DATA_BITS samples -> STOP (or PARITY when the optional feature is enabled).
- STOP, sampled at cnt==15:
  - rx_s==1: RX_DATA<=shift register; RX_STATUS=1 for exactly that next cycle; -> IDLE.
  - rx_s==0: RX_FERR=1 for one cycle; RX_DATA unchanged; -> BREAK.
- BREAK: waits for rx_s==1, then -> IDLE. A held-low line yields exactly one RX_FERR and no false starts.
- Timing:
  - Leaving STOP at mid-stop-bit gives a half-bit of margin, so back-to-back frames with a 1-bit stop are received.
  - A new start edge is accepted on the cycle after returning to IDLE.
  - Latency from the start-bit falling edge on UART_RX to the RX_STATUS pulse: 2 + 1 + (START_SAMPLE+1) + 16*(DATA_BITS+1) cycles = 155 at the defaults, ±1 cycle of edge-phase uncertainty.
- RX_STATUS, RX_FERR and RX_PERR are mutually exclusive, and each is high for exactly one cycle.
- RX_BUSY = (state != IDLE).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: after the last data bit, a PARITY state samples one extra bit at cnt==15, then -> STOP.
  - If the XOR of the data bits and the parity bit is 1: at the STOP sample, RX_PERR pulses instead of RX_STATUS, and RX_DATA is not updated.
  - A framing error takes priority over a parity error.
  - Latency grows by 16 cycles.
- Not defined: no PARITY state; RX_PERR is constant 0.

Test Plan:
- Reset then idle line for 100 cycles -> all outputs 0, RX_BUSY=0.
- Send 0xA5 as 8N1, 16 clocks per bit -> RX_STATUS pulses once, RX_DATA=0xA5, RX_FERR=0.
- Send 0x3C then immediately 0xFF, 1-bit stop each -> two RX_STATUS pulses, RX_DATA=0x3C then 0xFF.
- 5-cycle low glitch on an idle line -> no flags, RX_BUSY returns to 0 within 12 cycles, then 0x55 is received correctly.
- Frame 0x12 with stop bit forced 0, line held low 64 cycles, then high -> exactly one RX_FERR pulse, RX_DATA keeps its previous value.
- Assert reset during the 4th data bit of 0x81, release, then send 0x7E -> no strobe for the aborted frame; RX_DATA=0x7E after the second frame.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> RX_STATUS; 0x07 with parity bit 0 -> RX_PERR, RX_DATA unchanged.
